// File: rtl/serial_sum_deser.sv
// Serial-to-parallel collector for the four-operand serial adder sum stream.
// Assembles LSB-first frames of WIDTH+2 bits into a double-buffered valid/ready word.
module serial_sum_deser #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sum_in,
   input  logic             out_ready,
   output logic [WIDTH+1:0] out_data,
   output logic             out_valid,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err
);

   localparam int unsigned FW = WIDTH + 2;
   localparam int unsigned CW = $clog2(FW);
   localparam logic [CW-1:0] CntLast = CW'(FW - 1);
   localparam logic [CW-1:0] CntOne  = CW'(1);

   typedef enum logic {
      StIdle,
      StShift
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [FW-1:0]   sr_q, sr_d;
   logic [FW-1:0]   data_q, data_d;
   logic            valid_q, valid_d;
   logic            overrun_q, overrun_d;
   logic            frame_err_q, frame_err_d;

   logic [FW-1:0]   sr_shift;
   logic            done;
   logic            xfer;

   // New bits enter at the MSB; after FW samples bit 0 has reached position 0.
   assign sr_shift = {sum_in, sr_q[FW-1:1]};
   assign xfer     = valid_q & out_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      data_d      = data_q;
      valid_d     = valid_q;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
      done        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               sr_d    = {sum_in, {(FW-1){1'b0}}};
               cnt_d   = CntOne;
               state_d = StShift;
            end
         end
         StShift: begin
            if (start) begin
               frame_err_d = 1'b1;
               sr_d        = {sum_in, {(FW-1){1'b0}}};
               cnt_d       = CntOne;
            end else if (cnt_q == CntLast) begin
               done    = 1'b1;
               sr_d    = sr_shift;
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               sr_d  = sr_shift;
               cnt_d = cnt_q + CntOne;
            end
         end
         default: state_d = StIdle;
      endcase

      // A completion may reuse the output slot only if it is empty or drains on this edge.
      if (done) begin
         if (!valid_q || xfer) begin
            data_d  = sr_shift;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         sr_q        <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign busy      = (state_q == StShift);
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_sum_deser.sv
// Self-checking bench for serial_sum_deser: directed frame table, corner sequences,
// and randomized traffic compared against a frame-level reference model.
module tb_serial_sum_deser;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned FW    = WIDTH + 2;

   logic            clk;
   logic            rst;
   logic            start;
   logic            sum_in;
   logic            out_ready;
   logic [FW-1:0]   out_data;
   logic            out_valid;
   logic            busy;
   logic            overrun;
   logic            frame_err;

   int n_checks;
   int n_errors;

   // Reference model state: bits gathered so far, and the output slot.
   int m_busy, m_cnt, m_word, m_data, m_valid, m_ovr, m_ferr;

   serial_sum_deser #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sum_in    (sum_in),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .busy      (busy),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [FW-1:0] word;
      logic          rdy_body;
      logic          rdy_last;
      logic [FW-1:0] exp_data;
      logic          exp_valid;
      logic          exp_ovr;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 0;
      m_cnt   = 0;
      m_word  = 0;
      m_data  = 0;
      m_valid = 0;
      m_ovr   = 0;
      m_ferr  = 0;
   endtask

   task automatic model_step(input logic st, input logic b, input logic rdy);
      int xfer;
      int done;
      xfer   = (m_valid != 0 && rdy) ? 1 : 0;
      m_ferr = (m_busy != 0 && st) ? 1 : 0;
      m_ovr  = 0;
      done   = 0;
      if (st) begin
         m_word = int'(b);
         m_cnt  = 1;
         m_busy = 1;
      end else if (m_busy != 0) begin
         m_word = m_word | (int'(b) << m_cnt);
         m_cnt++;
         if (m_cnt == FW) begin
            done   = 1;
            m_busy = 0;
            m_cnt  = 0;
         end
      end
      if (done != 0) begin
         if (m_valid == 0 || xfer != 0) begin
            m_data  = m_word;
            m_valid = 1;
         end else begin
            m_ovr = 1;
         end
      end else if (xfer != 0) begin
         m_valid = 0;
      end
   endtask

   task automatic check_all();
      chk("out_data",  32'(out_data),  32'(m_data));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("overrun",   32'(overrun),   32'(m_ovr));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
   endtask

   task automatic cycle(input logic st, input logic b, input logic rdy);
      start     = st;
      sum_in    = b;
      out_ready = rdy;
      @(posedge clk);
      model_step(st, b, rdy);
      #1;
      check_all();
   endtask

   task automatic send_frame(input logic [FW-1:0] w, input logic rb, input logic rl);
      for (int k = 0; k < FW; k++) begin
         cycle((k == 0), w[k], (k == FW - 1) ? rl : rb);
      end
   endtask

   // Asserts reset asynchronously, checks outputs clear at once, then releases.
   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all();
   endtask

   initial begin
      logic [FW-1:0] w;
      int busy_cycles;

      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b0;
      start     = 1'b0;
      sum_in    = 1'b0;
      out_ready = 1'b0;
      model_reset();

      tbl[0] = '{10'h3FC, 1'b1, 1'b1, 10'h3FC, 1'b1, 1'b0};
      tbl[1] = '{10'h001, 1'b1, 1'b0, 10'h001, 1'b1, 1'b0};
      tbl[2] = '{10'h2AA, 1'b0, 1'b1, 10'h2AA, 1'b1, 1'b0};
      tbl[3] = '{10'h155, 1'b1, 1'b0, 10'h155, 1'b1, 1'b0};
      tbl[4] = '{10'h0F0, 1'b0, 1'b0, 10'h155, 1'b1, 1'b1};
      tbl[5] = '{10'h3FF, 1'b1, 1'b1, 10'h3FF, 1'b1, 1'b0};

      #3;
      do_reset();
      chk("reset_out_data", 32'(out_data), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);

      // Lone start: busy covers the remaining FW-1 sampling cycles.
      busy_cycles = 0;
      cycle(1'b1, 1'b0, 1'b0);
      if (busy) busy_cycles++;
      for (int i = 0; i < FW + 2; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (busy) busy_cycles++;
      end
      chk("busy_duration", 32'(busy_cycles), 32'(FW - 1));
      chk("zero_frame_valid", 32'(out_valid), 32'h1);
      cycle(1'b0, 1'b0, 1'b1);
      chk("zero_frame_drained", 32'(out_valid), 32'h0);

      for (int i = 0; i < 6; i++) begin
         send_frame(tbl[i].word, tbl[i].rdy_body, tbl[i].rdy_last);
         chk($sformatf("tbl%0d_data", i),  32'(out_data),  32'(tbl[i].exp_data));
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d_ovr", i),   32'(overrun),   32'(tbl[i].exp_ovr));
      end
      cycle(1'b0, 1'b0, 1'b1);
      chk("tbl_drain_valid", 32'(out_valid), 32'h0);

      // Restart after four bits.
      cycle(1'b1, 1'b1, 1'b1);
      for (int k = 1; k < 4; k++) cycle(1'b0, 1'b1, 1'b1);
      w = 10'h123;
      cycle(1'b1, w[0], 1'b0);
      chk("restart_frame_err", 32'(frame_err), 32'h1);
      for (int k = 1; k < FW; k++) cycle(1'b0, w[k], 1'b0);
      chk("restart_data", 32'(out_data), 32'h123);
      chk("restart_valid", 32'(out_valid), 32'h1);
      cycle(1'b0, 1'b0, 1'b1);

      // Start coinciding with the last bit aborts the frame.
      w = 10'h2AA;
      for (int k = 0; k < FW - 1; k++) cycle((k == 0), w[k], 1'b1);
      w = 10'h201;
      cycle(1'b1, w[0], 1'b1);
      chk("lastbit_frame_err", 32'(frame_err), 32'h1);
      chk("lastbit_no_valid", 32'(out_valid), 32'h0);
      chk("lastbit_busy", 32'(busy), 32'h1);
      for (int k = 1; k < FW; k++) cycle(1'b0, w[k], 1'b0);
      chk("lastbit_new_data", 32'(out_data), 32'h201);
      cycle(1'b0, 1'b0, 1'b1);

      // Asynchronous reset at bit 5 of a frame, with an older word still pending.
      send_frame(10'h0AB, 1'b0, 1'b0);
      w = 10'h3FF;
      for (int k = 0; k < 5; k++) cycle((k == 0), w[k], 1'b0);
      do_reset();
      chk("midreset_valid", 32'(out_valid), 32'h0);
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0);
      chk("midreset_no_output", 32'(out_valid), 32'h0);
      send_frame(10'h3FF, 1'b1, 1'b1);
      chk("midreset_data", 32'(out_data), 32'h3FF);
      chk("midreset_valid_after", 32'(out_valid), 32'h1);

      // Random traffic, every cycle compared against the model.
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
